// File: rtl/char_ram_arbiter.sv
`timescale 1ns/1ps
// char_ram_arbiter
// Shares one single-port character RAM between the video fetch path, two
// writer clients and an optional clear sequencer. Video always wins so scan-out
// never stalls; the clear sequencer comes next; the writers share whatever is
// left round-robin. All RAM-side outputs are registered, so a grant in one
// cycle shows up on mem_* in the next.
//
// Optional feature: define CHAR_RAM_ARBITER_CLEAR_EN to build the clear
// sequencer. Without it clr_start is ignored and clr_busy is tied low.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   vid_req / vid_addr           video fetch request pulse and cell address
//   vid_valid / vid_data         fetched cell, two cycles after vid_req
//   wrN_valid/addr/data/ready    writer N handshake (N = 0, 1)
//   clr_start / clr_busy         clear request pulse and clear-in-progress
//   mem_en/we/addr/wdata         registered RAM controls
//   mem_rdata                    RAM read data, one cycle after mem_en
module char_ram_arbiter #(
  parameter int cols = 80,
  parameter int rows = 30,
  parameter int w_data = 8,
  parameter logic [w_data-1:0] blank_char = 8'h20,
  parameter int w_addr = $clog2(cols * rows)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [w_addr-1:0] vid_addr,
  output logic              vid_valid,
  output logic [w_data-1:0] vid_data,
  input  logic              wr0_valid,
  input  logic [w_addr-1:0] wr0_addr,
  input  logic [w_data-1:0] wr0_data,
  output logic              wr0_ready,
  input  logic              wr1_valid,
  input  logic [w_addr-1:0] wr1_addr,
  input  logic [w_data-1:0] wr1_data,
  output logic              wr1_ready,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [w_addr-1:0] mem_addr,
  output logic [w_data-1:0] mem_wdata,
  input  logic [w_data-1:0] mem_rdata
);

  localparam int unsigned cells = cols * rows;
  localparam logic [w_addr-1:0] last_cell = w_addr'(cells - 1);

  logic grant_vid, grant_clr, grant_wr0, grant_wr1;
  logic wr0_in_range, wr1_in_range;
  logic rr_q, rr_d;
  logic vid_rd_q, vid_rd_d;
  logic vid_valid_q, vid_valid_d;
  logic mem_en_q, mem_en_d;
  logic mem_we_q, mem_we_d;
  logic [w_addr-1:0] mem_addr_q, mem_addr_d;
  logic [w_data-1:0] mem_wdata_q, mem_wdata_d;
  logic [w_addr-1:0] clr_addr;

`ifdef CHAR_RAM_ARBITER_CLEAR_EN
  typedef enum logic {CLR_IDLE, CLR_CLEAR} clr_state_e;

  clr_state_e clr_state_q, clr_state_d;
  logic [w_addr-1:0] clr_cnt_q, clr_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_state_q <= CLR_IDLE;
      clr_cnt_q   <= '0;
    end else begin
      clr_state_q <= clr_state_d;
      clr_cnt_q   <= clr_cnt_d;
    end
  end

  // The counter only advances on cycles the sequencer actually owns the RAM,
  // so video fetches simply stretch the clear. clr_start while clearing is
  // ignored rather than restarting.
  always_comb begin
    clr_state_d = clr_state_q;
    clr_cnt_d   = clr_cnt_q;
    case (clr_state_q)
      CLR_IDLE: begin
        if (clr_start) begin
          clr_state_d = CLR_CLEAR;
          clr_cnt_d   = '0;
        end
      end
      CLR_CLEAR: begin
        if (grant_clr) begin
          if (clr_cnt_q == last_cell) begin
            clr_state_d = CLR_IDLE;
            clr_cnt_d   = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        clr_state_d = CLR_IDLE;
        clr_cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    clr_busy = (clr_state_q == CLR_CLEAR);
    clr_addr = clr_cnt_q;
  end
`else
  logic unused_clr_start;
  assign unused_clr_start = clr_start;
  assign clr_busy = 1'b0;
  assign clr_addr = '0;
`endif

  assign wr0_in_range = (32'(wr0_addr) < cells);
  assign wr1_in_range = (32'(wr1_addr) < cells);

  // Fixed-priority grant: video, then clear, then the writers. rr_q=0 means
  // wr0 wins a tie. Gated by rst so the combinational readies are low in reset.
  always_comb begin
    grant_vid = 1'b0;
    grant_clr = 1'b0;
    grant_wr0 = 1'b0;
    grant_wr1 = 1'b0;
    if (!rst) begin
      if (vid_req) begin
        grant_vid = 1'b1;
      end else if (clr_busy) begin
        grant_clr = 1'b1;
      end else if (wr0_valid && wr1_valid) begin
        if (rr_q) grant_wr1 = 1'b1;
        else      grant_wr0 = 1'b1;
      end else if (wr0_valid) begin
        grant_wr0 = 1'b1;
      end else if (wr1_valid) begin
        grant_wr1 = 1'b1;
      end
    end
  end

  // After a writer grant the pointer favours the other writer; out-of-range
  // writes still count as grants.
  always_comb begin
    rr_d = rr_q;
    if (grant_wr0)      rr_d = 1'b1;
    else if (grant_wr1) rr_d = 1'b0;
  end

  // Next-cycle RAM command. Out-of-range writes are acknowledged but leave
  // mem_en low so the RAM is never touched outside the text area.
  always_comb begin
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (grant_vid) begin
      mem_en_d   = 1'b1;
      mem_addr_d = vid_addr;
    end else if (grant_clr) begin
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = clr_addr;
      mem_wdata_d = blank_char;
    end else if (grant_wr0 && wr0_in_range) begin
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = wr0_addr;
      mem_wdata_d = wr0_data;
    end else if (grant_wr1 && wr1_in_range) begin
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = wr1_addr;
      mem_wdata_d = wr1_data;
    end
  end

  // Two-stage video tag: stage one rides alongside mem_en, stage two lines up
  // with the RAM's read data.
  always_comb begin
    vid_rd_d    = grant_vid;
    vid_valid_d = vid_rd_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q        <= 1'b0;
      vid_rd_q    <= 1'b0;
      vid_valid_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      rr_q        <= rr_d;
      vid_rd_q    <= vid_rd_d;
      vid_valid_q <= vid_valid_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign wr0_ready = grant_wr0;
  assign wr1_ready = grant_wr1;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign vid_valid = vid_valid_q;
  // Gated so the output reads zero whenever no fetch result is presented.
  assign vid_data  = vid_valid_q ? mem_rdata : '0;

endmodule

// File: doc/char_ram_arbiter.md
Name: char_ram_arbiter

Overview:
Shares one single-port character RAM (cols x rows text cells) between three users: the VGA character fetch path, two writer clients, and an internal clear sequencer. The VGA fetch has absolute priority so scan-out never stalls. The two writers are served round-robin through a valid/ready handshake. The block sits between the text-mode renderer, the writer clients (UART/keyboard front-ends) and the RAM macro.

Parameters:
cols, 80, text columns (640 px / 8 px glyph)
rows, 30, text rows (480 px / 16 px glyph)
w_data, 8, bits per cell (character code)
blank_char, 8'h20, value written by the clear sequencer
w_addr, $clog2(cols*rows), cell address width (12 for the defaults)

Ports:
clk  in  1  clock
rst  in  1  reset
vid_req  in  1  video fetch request, single-cycle pulse
vid_addr  in  w_addr  video fetch cell address, valid with vid_req
vid_valid  out  1  vid_data valid pulse
vid_data  out  w_data  fetched cell, equal to mem_rdata
wr0_valid  in  1  writer 0 request
wr0_addr  in  w_addr  writer 0 cell address
wr0_data  in  w_data  writer 0 cell value
wr0_ready  out  1  writer 0 accepted this cycle
wr1_valid, wr1_addr, wr1_data, wr1_ready  as writer 0, for writer 1
clr_start  in  1  clear request pulse
clr_busy  out  1  clear in progress
mem_en  out  1  RAM access enable
mem_we  out  1  RAM write enable
mem_addr  out  w_addr  RAM address
mem_wdata  out  w_data  RAM write data
mem_rdata  in  w_data  RAM read data, 1-cycle latency after mem_en

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. While rst is high:
  - all outputs are 0, including vid_valid, wrX_ready, clr_busy and all mem_* outputs.
  - round-robin pointer favours wr0.
  - clear counter is 0.
  - in-flight video read is discarded; no vid_valid follows.
- Per-cycle grant, combinational from current inputs and state, in priority order:
  1. vid_req.
  2. Clear sequencer, if clr_busy.
  3. Writers, round-robin, only when clr_busy=0.
- At most one grant per cycle.
- wrX_ready=1 only in the cycle that writer is granted. A transfer occurs when wrX_valid && wrX_ready.
- Writers must hold valid, addr and data stable until ready. The arbiter never drops an asserted valid.
- Round-robin: the pointer toggles to the other writer after each writer grant. With only one writer valid, that writer is granted every free cycle.
- mem_* outputs are registered. A grant in cycle N drives mem_en/mem_we/mem_addr/mem_wdata in cycle N+1. mem_en=0 in cycles with no grant.
- Video read: vid_req in cycle N gives mem_en=1 and mem_we=0 in N+1, then vid_valid=1 in N+2 with vid_data=mem_rdata (combinational passthrough).
- Back-to-back vid_req, one per cycle, is fully pipelined.
- Out-of-range write (addr >= cols*rows): the writer is granted (ready=1) and the write is discarded. mem_en stays 0 in N+1. The pointer still toggles.
- Out-of-range vid_addr: the read is issued unchanged. The address is the renderer's responsibility.
- Clear sequencer:
  - States: IDLE and CLEAR.
  - IDLE: clr_start moves to CLEAR with counter=0; clr_busy=1 from the next cycle.
  - CLEAR: each granted cycle (no vid_req) issues a write of blank_char at the counter address and increments the counter.
  - The grant at counter=cols*rows-1 returns to IDLE; clr_busy=0 the following cycle.
  - clr_start during CLEAR is ignored.
  - Writers see ready=0 for the whole of CLEAR.
- Simultaneous vid_req and clr_start in IDLE: video is granted, CLEAR is entered next cycle.

Optional Feature:
Macro CHAR_RAM_ARBITER_CLEAR_EN.
- Defined: clear sequencer present as described.
- Undefined: no sequencer logic; clr_start is ignored; clr_busy is tied to 0; writers compete only with video.

Test Plan:
1. wr0_valid=1, addr=5, data=8'h41, no other traffic -> wr0_ready=1 same cycle; next cycle mem_en=1, mem_we=1, mem_addr=5, mem_wdata=8'h41.
2. wr0 and wr1 both held valid, no video -> wr0_ready/wr1_ready alternate every cycle starting with wr0; 10 cycles give 5 writes each, in order.
3. vid_req every cycle for 8 cycles with both writers valid -> both readies stay 0; vid_valid follows each vid_req by 2 cycles; mem_we=0 throughout; writers resume round-robin afterwards.
4. wr1 with addr=2400 (default params) -> wr1_ready=1; mem_en=0 next cycle; RAM content unchanged.
5. With macro defined, clr_start then vid_req every 8th cycle -> 2400 writes of 8'h20 at addresses 0..2399 in order, paused only on video cycles. clr_busy stays high 2400+stall cycles; wr0_ready=0 throughout. Repeat without the macro -> clr_busy stays 0 and there are no writes.
6. rst asserted mid-clear (counter=1000) and with a read in flight -> clr_busy, mem_en and vid_valid go to 0 immediately. After release, clr_start restarts from address 0.
